keypoint_write_arbiter: RTL and testbench

// - Merges the two keypoint streams (scale pair 0: DoG layers 0-2, scale pair 1: layers 2-4) into one shared keypoint SRAM.
// - Sits between the two filter_keypoint result paths and a single-port 2K-entry keypoint SRAM, replacing the per-scale SRAMs.
// - Buffers each stream, arbitrates round-robin, tags each entry with its scale, counts entries and signals frame completion.

---
 rtl/sift_pkg.sv | 18 +
 rtl/kp_fifo.sv | 54 +++++
 rtl/keypoint_write_arbiter.sv | 160 ++++++++++++++++
 tb/tb_keypoint_write_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sift_pkg.sv
// Shared SIFT keypoint definitions: payload field widths, SRAM geometry and
// the state encoding of the keypoint write arbiter.
package sift_pkg;

  localparam int unsigned KP_ROW_W  = 9;
  localparam int unsigned KP_COL_W  = 10;
  localparam int unsigned KP_W      = KP_ROW_W + KP_COL_W;
  localparam int unsigned KP_ADDR_W = 11;
  localparam int unsigned KP_MAX    = 2048;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } kpw_state_e;

endpackage

// File: rtl/kp_fifo.sv
// Small synchronous FIFO holding one scale's keypoints ahead of the arbiter.
// Power-of-two depth; rdata shows the head entry whenever empty is low.
module kp_fifo #(
  parameter int unsigned W = 19,
  parameter int unsigned D = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = (D > 1) ? $clog2(D) : 1;

  logic [W-1:0]  mem [D];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  // Pointers and occupancy; simultaneous push and pop leave count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == (AW+1)'(D));
  assign empty = (count == '0);

endmodule

// File: rtl/keypoint_write_arbiter.sv
// Merges the two per-scale keypoint streams into one shared keypoint SRAM:
// per-port FIFOs, round-robin pop, registered write stage, count and done.
module keypoint_write_arbiter #(
  parameter int unsigned KP_W   = sift_pkg::KP_W,
  parameter int unsigned ADDR_W = sift_pkg::KP_ADDR_W,
  parameter int unsigned MAX_KP = sift_pkg::KP_MAX,
  parameter int unsigned FIFO_D = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              flush,
  input  logic              kp0_valid,
  input  logic [KP_W-1:0]   kp0_data,
  output logic              kp0_ready,
  input  logic              kp1_valid,
  input  logic [KP_W-1:0]   kp1_data,
  output logic              kp1_ready,
  output logic              kp_we,
  output logic [ADDR_W-1:0] kp_addr,
  output logic [KP_W:0]     kp_din,
  output logic [ADDR_W:0]   kp_count,
  output logic              overflow,
  output logic              done
);

  import sift_pkg::*;

  localparam logic [ADDR_W:0] CAP = (ADDR_W+1)'(MAX_KP);

  kpw_state_e state_q, state_d;
  logic       rr_q, rr_d;
  logic       clr;
  logic       push0, push1, pop0, pop1;
  logic       full0, full1, empty0, empty1;
  logic [KP_W-1:0] rdata0, rdata1;

  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [KP_W:0]     din_q;
  logic [ADDR_W:0]   count_q;
  logic              ovf_q;
  logic              done_q;

  kp_fifo #(.W(KP_W), .D(FIFO_D)) u_fifo0 (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .push  (push0),
    .wdata (kp0_data),
    .pop   (pop0),
    .rdata (rdata0),
    .full  (full0),
    .empty (empty0)
  );

  kp_fifo #(.W(KP_W), .D(FIFO_D)) u_fifo1 (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .push  (push1),
    .wdata (kp1_data),
    .pop   (pop1),
    .rdata (rdata1),
    .full  (full1),
    .empty (empty1)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
    end
  end

  // Next state, accept handshake and the one-pop-per-cycle arbiter.
  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    clr       = 1'b0;
    kp0_ready = 1'b0;
    kp1_ready = 1'b0;
    pop0      = 1'b0;
    pop1      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          clr     = 1'b1;
          rr_d    = 1'b0;
        end
      end
      RUN: begin
        kp0_ready = !full0;
        kp1_ready = !full1;
        if (flush) state_d = DRAIN;
      end
      DRAIN: begin
        if (empty0 && empty1) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (state_q == RUN || state_q == DRAIN) begin
      if (!empty0 && !empty1) begin
        pop0 = !rr_q;
        pop1 = rr_q;
        rr_d = !rr_q;
      end else if (!empty0) begin
        pop0 = 1'b1;
      end else if (!empty1) begin
        pop1 = 1'b1;
      end
    end

    push0 = kp0_valid && kp0_ready;
    push1 = kp1_valid && kp1_ready;
  end

  // Write stage: a popped entry lands in the SRAM one cycle later unless full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      we_q   <= 1'b0;
      done_q <= (state_d == DONE);
      if (clr) begin
        count_q <= '0;
        ovf_q   <= 1'b0;
      end else if (pop0 || pop1) begin
        if (count_q < CAP) begin
          we_q    <= 1'b1;
          addr_q  <= count_q[ADDR_W-1:0];
          din_q   <= {pop1, (pop1 ? rdata1 : rdata0)};
          count_q <= count_q + (ADDR_W+1)'(1);
        end else begin
          ovf_q <= 1'b1;
        end
      end
    end
  end

  assign kp_we    = we_q;
  assign kp_addr  = addr_q;
  assign kp_din   = din_q;
  assign kp_count = count_q;
  assign overflow = ovf_q;
  assign done     = done_q;

endmodule

// File: tb/tb_keypoint_write_arbiter.sv
// Directed bench for keypoint_write_arbiter: a full-size instance and an
// 8-entry instance share stimulus; SRAM writes are collected and compared.
module tb_keypoint_write_arbiter;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic        kp0_valid, kp1_valid;
  logic [18:0] kp0_data, kp1_data;

  logic        kp0_ready, kp1_ready, kp_we, overflow, done;
  logic [10:0] kp_addr;
  logic [19:0] kp_din;
  logic [11:0] kp_count;

  logic        c_kp0_ready, c_kp1_ready, c_kp_we, c_overflow, c_done;
  logic [10:0] c_kp_addr;
  logic [19:0] c_kp_din;
  logic [11:0] c_kp_count;

  typedef struct {
    logic [10:0] addr;
    logic [19:0] din;
  } wr_t;

  wr_t wq[$];
  wr_t cwq[$];
  int  done_n, cdone_n;
  int  n_cmp = 0;
  int  n_fail = 0;

  bit rdy0_exp [10] = '{1, 1, 1, 1, 1, 1, 1, 0, 1, 0};
  bit rdy1_exp [10] = '{1, 1, 1, 1, 1, 1, 0, 1, 0, 1};

  keypoint_write_arbiter u_dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush),
    .kp0_valid(kp0_valid), .kp0_data(kp0_data), .kp0_ready(kp0_ready),
    .kp1_valid(kp1_valid), .kp1_data(kp1_data), .kp1_ready(kp1_ready),
    .kp_we(kp_we), .kp_addr(kp_addr), .kp_din(kp_din),
    .kp_count(kp_count), .overflow(overflow), .done(done)
  );

  keypoint_write_arbiter #(.MAX_KP(8)) u_cap (
    .clk(clk), .rst(rst), .start(start), .flush(flush),
    .kp0_valid(kp0_valid), .kp0_data(kp0_data), .kp0_ready(c_kp0_ready),
    .kp1_valid(kp1_valid), .kp1_data(kp1_data), .kp1_ready(c_kp1_ready),
    .kp_we(c_kp_we), .kp_addr(c_kp_addr), .kp_din(c_kp_din),
    .kp_count(c_kp_count), .overflow(c_overflow), .done(c_done)
  );

  always #5 clk = ~clk;

  // Collect SRAM writes and done pulses from both instances.
  always @(negedge clk) begin
    if (kp_we)   wq.push_back('{kp_addr, kp_din});
    if (c_kp_we) cwq.push_back('{c_kp_addr, c_kp_din});
    if (done)    done_n++;
    if (c_done)  cdone_n++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic clear_mon();
    wq.delete();
    cwq.delete();
    done_n  = 0;
    cdone_n = 0;
  endtask

  task automatic check_writes(input string nm, input wr_t q[$], input wr_t t[]);
    check({nm, "_nwr"}, q.size(), t.size());
    for (int i = 0; i < t.size(); i++) begin
      if (i < q.size()) begin
        check($sformatf("%s_addr%0d", nm, i), 32'(q[i].addr), 32'(t[i].addr));
        check($sformatf("%s_din%0d", nm, i), 32'(q[i].din), 32'(t[i].din));
      end
    end
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while ((done_n == 0 || cdone_n == 0) && n < 100) begin
      step();
      n++;
    end
    repeat (3) step();
    check({nm, "_done_once"}, done_n, 1);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Handshaked stream: each port holds its beat until accepted.
  task automatic stream(input int n0, input int n1, input int rbase, input bit chk_rdy);
    int  i0 = 0;
    int  i1 = 0;
    int  cyc = 0;
    bit  a0, a1;
    while ((i0 < n0 || i1 < n1) && cyc < 200) begin
      kp0_valid = (i0 < n0);
      kp0_data  = {9'(rbase + i0), 10'd100};
      kp1_valid = (i1 < n1);
      kp1_data  = {9'(rbase + i1), 10'd101};
      if (chk_rdy && cyc < 10) begin
        check($sformatf("rdy0_c%0d", cyc), 32'(kp0_ready), 32'(rdy0_exp[cyc]));
        check($sformatf("rdy1_c%0d", cyc), 32'(kp1_ready), 32'(rdy1_exp[cyc]));
      end
      a0 = kp0_valid && kp0_ready;
      a1 = kp1_valid && kp1_ready;
      step();
      if (a0) i0++;
      if (a1) i1++;
      cyc++;
    end
    kp0_valid = 1'b0;
    kp1_valid = 1'b0;
    check("stream_budget", 32'(cyc < 200), 32'd1);
  endtask

  wr_t t1[], t2[], t4[], t6[];

  initial begin
    t1 = new[5];
    for (int i = 0; i < 5; i++) t1[i] = '{11'(i), {1'b0, 9'(i + 1), 10'd7}};
    t2 = new[16];
    for (int k = 0; k < 16; k++) t2[k] = '{11'(k), {1'(k % 2), 9'(k / 2), 10'(100 + k % 2)}};
    t4 = new[8];
    for (int k = 0; k < 8; k++) t4[k] = '{11'(k), {1'b0, 9'(20 + k), 10'd100}};
    t6 = new[1];
    t6[0] = '{11'd0, {1'b0, 9'd9, 10'd9}};

    rst = 1'b1; start = 1'b0; flush = 1'b0;
    kp0_valid = 1'b0; kp1_valid = 1'b0; kp0_data = '0; kp1_data = '0;
    clear_mon();
    repeat (2) step();
    check("rst_we", 32'(kp_we), 0);
    check("rst_addr", 32'(kp_addr), 0);
    check("rst_din", 32'(kp_din), 0);
    check("rst_count", 32'(kp_count), 0);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_done", 32'(done), 0);
    check("rst_rdy0", 32'(kp0_ready), 0);
    check("rst_rdy1", 32'(kp1_ready), 0);
    rst = 1'b0;
    step();

    // Single stream; a start pulse mid-frame must be ignored.
    do_start();
    clear_mon();
    for (int i = 0; i < 5; i++) begin
      kp0_valid = 1'b1;
      kp0_data  = {9'(i + 1), 10'd7};
      start     = (i == 2);
      check($sformatf("t1_rdy%0d", i), 32'(kp0_ready), 1);
      step();
    end
    kp0_valid = 1'b0;
    start     = 1'b0;
    do_flush();
    wait_done("t1");
    check_writes("t1", wq, t1);
    check("t1_count", 32'(kp_count), 5);
    check("t1_ovf", 32'(overflow), 0);

    // Contention plus backpressure on both FIFOs.
    do_start();
    clear_mon();
    stream(8, 8, 0, 1'b1);
    do_flush();
    wait_done("t2");
    check_writes("t2", wq, t2);
    check("t2_count", 32'(kp_count), 16);

    // Capacity on the 8-entry instance.
    do_start();
    clear_mon();
    stream(10, 0, 20, 1'b0);
    do_flush();
    wait_done("t4");
    check_writes("t4", cwq, t4);
    check("t4_cap_count", 32'(c_kp_count), 8);
    check("t4_cap_ovf", 32'(c_overflow), 1);
    check("t4_cap_done", cdone_n, 1);
    check("t4_big_count", 32'(kp_count), 10);
    check("t4_big_ovf", 32'(overflow), 0);

    // Empty frame: start+flush together in IDLE, then flush with start in RUN.
    clear_mon();
    start = 1'b1;
    flush = 1'b1;
    step();
    start = 1'b0;
    flush = 1'b0;
    check("t5_run_rdy", 32'(kp0_ready), 1);
    check("t5_count_clr", 32'(c_kp_count), 0);
    check("t5_ovf_clr", 32'(c_overflow), 0);
    start = 1'b1;
    flush = 1'b1;
    step();
    start = 1'b0;
    flush = 1'b0;
    check("t5_drain_done", 32'(done), 0);
    check("t5_drain_rdy", 32'(kp0_ready), 0);
    step();
    check("t5_done_pulse", 32'(done), 1);
    step();
    check("t5_done_end", 32'(done), 0);
    check("t5_idle_rdy", 32'(kp0_ready), 0);
    check("t5_nwr", wq.size(), 0);
    check("t5_count", 32'(kp_count), 0);
    check("t5_done_n", done_n, 1);

    // Reset in DRAIN with three entries still queued.
    do_start();
    stream(3, 3, 40, 1'b0);
    do_flush();
    rst = 1'b1;
    step();
    check("t6_we", 32'(kp_we), 0);
    check("t6_addr", 32'(kp_addr), 0);
    check("t6_din", 32'(kp_din), 0);
    check("t6_count", 32'(kp_count), 0);
    check("t6_ovf", 32'(overflow), 0);
    check("t6_done", 32'(done), 0);
    check("t6_rdy0", 32'(kp0_ready), 0);
    check("t6_rdy1", 32'(kp1_ready), 0);
    rst = 1'b0;
    step();
    clear_mon();
    repeat (3) step();
    check("t6_quiet", wq.size(), 0);
    do_start();
    kp0_valid = 1'b1;
    kp0_data  = {9'd9, 10'd9};
    step();
    kp0_valid = 1'b0;
    do_flush();
    wait_done("t6");
    check_writes("t6", wq, t6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
